// File: rtl/acc_dp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_dp_pkg
// Description : Shared encodings for the accumulator datapath: ALU operation
//               codes, serial-multiplier state encoding and the register
//               source-select values used on the mux inputs.
// Revision    : 1.0 - initial release
// ============================================================================
package acc_dp_pkg;

  // ALU operation codes (opALU)
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_NOT  = 3'd4;
  localparam logic [2:0] ALU_PASS = 3'd5;
  localparam logic [2:0] ALU_SHL  = 3'd6;
  localparam logic [2:0] ALU_SHR  = 3'd7;

  // Serial multiplier states
  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_RUN  = 2'd1,
    MS_DONE = 2'd2
  } mul_state_e;

  // Register source selects
  localparam logic MUXPC_INC  = 1'b0;  // PC <= PC + 1
  localparam logic MUXPC_IR   = 1'b1;  // PC <= IR address field
  localparam logic MUXMAR_PC  = 1'b0;  // MAR <= PC
  localparam logic MUXMAR_IR  = 1'b1;  // MAR <= IR address field
  localparam logic MUXACC_ALU = 1'b0;  // ACC <= ALU result
  localparam logic MUXACC_MDR = 1'b1;  // ACC <= MDR

endpackage : acc_dp_pkg
`default_nettype wire

// File: rtl/mul_serial.sv
`default_nettype none
// ============================================================================
// Module      : mul_serial
// Description : Unsigned W x W shift-add multiplier, one partial product per
//               clock. A start pulse in IDLE latches the operands; W RUN
//               cycles follow, then a single DONE cycle presents the product.
//               Starts outside IDLE are ignored.
// Ports       : clk, rst (async, active-high)
//               start  in  1    begin a multiply (honoured only in IDLE)
//               a, b   in  W    operands, sampled on the start edge
//               busy   out 1    high while in RUN
//               done   out 1    high for the single DONE cycle
//               prod   out 2W   product register (valid while done)
// Revision    : 1.0 - initial release
// ============================================================================
module mul_serial #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] prod
);

  import acc_dp_pkg::*;

  localparam int              CNT_W     = $clog2(W) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

  mul_state_e       state_q, state_d;
  logic [2*W-1:0]   mcand_q, mcand_d;
  logic [2*W-1:0]   prod_q,  prod_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MS_IDLE;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      MS_IDLE: begin
        if (start) begin
          mcand_d  = {{W{1'b0}}, a};
          mplier_d = b;
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = MS_RUN;
        end
      end
      MS_RUN: begin
        // Multiplicand walks left while the multiplier walks right, so the
        // lsb of mplier_q always selects the correctly weighted addend.
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = MS_DONE;
        end
      end
      MS_DONE: begin
        state_d = MS_IDLE;
      end
      default: begin
        state_d = MS_IDLE;
      end
    endcase
  end

  assign busy = (state_q == MS_RUN);
  assign done = (state_q == MS_DONE);
  assign prod = prod_q;

endmodule : mul_serial
`default_nettype wire

// File: rtl/acc_datapath_gen.sv
`default_nettype none
// ============================================================================
// Module      : acc_datapath_gen
// Description : Accumulator datapath for the multi-cycle CPU. Holds PC, IR,
//               ACC, MDR, MAR and a carry flag, an 8-op combinational ALU and
//               a serial multiplier whose product is written back into ACC.
// Ports       : clk, rst (async, active-high)
//               muxPC/muxMAR/muxACC       register source selects
//               loadPC/MAR/ACC/MDR/IR     register load enables
//               opALU      in  3          ALU operation
//               mul_start  in  1          multiply ACC.lo x MDR.lo
//               MemQ       in  DATA_W     memory read data
//               mul_busy   out 1          multiplier running
//               mul_done   out 1          product written to ACC this edge
//               opcode     out OP_W       IR opcode field
//               MemAddr    out ADDR_W     MAR
//               MemD       out DATA_W     ACC
//               zflag/nflag/cflag out 1   ACC zero / ACC sign / carry
// Revision    : 1.0 - initial release
// ============================================================================
module acc_datapath_gen #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int OP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              muxPC,
  input  logic              muxMAR,
  input  logic              muxACC,
  input  logic              loadPC,
  input  logic              loadMAR,
  input  logic              loadACC,
  input  logic              loadMDR,
  input  logic              loadIR,
  input  logic [2:0]        opALU,
  input  logic              mul_start,
  input  logic [DATA_W-1:0] MemQ,
  output logic              mul_busy,
  output logic              mul_done,
  output logic [OP_W-1:0]   opcode,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemD,
  output logic              zflag,
  output logic              nflag,
  output logic              cflag
);

  import acc_dp_pkg::*;

  localparam int HALF_W = DATA_W / 2;

  // Architectural registers
  logic [ADDR_W-1:0] pc_q,  pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q,  ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              cflag_q, cflag_d;

  // Combinational datapath
  logic [ADDR_W-1:0] ir_addr;
  logic [DATA_W:0]   add_ext;
  logic [DATA_W:0]   sub_ext;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic [DATA_W-1:0] mul_prod;

  // Address field sits at the top of IR, opcode at the bottom.
  assign ir_addr = ir_q[DATA_W-1 -: ADDR_W];

  // --------------------------------------------------------------------------
  // ALU
  // --------------------------------------------------------------------------
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    add_ext   = {1'b0, acc_q} + {1'b0, mdr_q};
    // Bit DATA_W of the widened difference is the borrow; carry is its
    // complement so cflag = 1 means ACC >= MDR (unsigned).
    sub_ext   = {1'b0, acc_q} - {1'b0, mdr_q};
    case (opALU)
      ALU_ADD: begin
        alu_res   = add_ext[DATA_W-1:0];
        alu_carry = add_ext[DATA_W];
      end
      ALU_SUB: begin
        alu_res   = sub_ext[DATA_W-1:0];
        alu_carry = ~sub_ext[DATA_W];
      end
      ALU_AND:  alu_res = acc_q & mdr_q;
      ALU_OR:   alu_res = acc_q | mdr_q;
      ALU_NOT:  alu_res = ~acc_q;
      ALU_PASS: alu_res = mdr_q;
      ALU_SHL: begin
        alu_res   = {acc_q[DATA_W-2:0], 1'b0};
        alu_carry = acc_q[DATA_W-1];
      end
      ALU_SHR: begin
        alu_res   = {1'b0, acc_q[DATA_W-1:1]};
        alu_carry = acc_q[0];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Serial multiplier: operands are the low halves of the current ACC/MDR, so
  // a loadACC on the start edge does not disturb the latched operand.
  // --------------------------------------------------------------------------
  mul_serial #(
    .W (HALF_W)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (acc_q[HALF_W-1:0]),
    .b     (mdr_q[HALF_W-1:0]),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // --------------------------------------------------------------------------
  // Register next-state
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d    = pc_q;
    mar_d   = mar_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    acc_d   = acc_q;
    cflag_d = cflag_q;

    if (loadPC) begin
      // Natural ADDR_W-bit wrap from all-ones back to zero.
      pc_d = (muxPC == MUXPC_IR) ? ir_addr : pc_q + ADDR_W'(1);
    end

    if (loadMAR) begin
      mar_d = (muxMAR == MUXMAR_IR) ? ir_addr : pc_q;
    end

    if (loadIR) begin
      ir_d = mdr_q;
    end

    if (loadMDR) begin
      mdr_d = MemQ;
    end

    // Multiplier writeback wins over a coincident loadACC.
    if (mul_done) begin
      acc_d   = mul_prod;
      cflag_d = 1'b0;
    end else if (loadACC) begin
      if (muxACC == MUXACC_MDR) begin
        acc_d = mdr_q;
      end else begin
        acc_d   = alu_res;
        cflag_d = alu_carry;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      mar_q   <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      acc_q   <= '0;
      cflag_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      acc_q   <= acc_d;
      cflag_q <= cflag_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: registered state only
  // --------------------------------------------------------------------------
  assign opcode  = ir_q[OP_W-1:0];
  assign MemAddr = mar_q;
  assign MemD    = acc_q;
  assign zflag   = (acc_q == '0);
  assign nflag   = acc_q[DATA_W-1];
  assign cflag   = cflag_q;

endmodule : acc_datapath_gen
`default_nettype wire

// File: tb/tb_acc_datapath_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_datapath_gen
// Description : Scoreboard bench for acc_datapath_gen. Two instances: the
//               default 16/8/8 configuration and a 24/10/8 configuration.
//               Stimulus pushes expected observations into queues; a monitor
//               on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_datapath_gen;

  import acc_dp_pkg::*;

  typedef struct packed {
    logic        muxPC;
    logic        muxMAR;
    logic        muxACC;
    logic        loadPC;
    logic        loadMAR;
    logic        loadACC;
    logic        loadMDR;
    logic        loadIR;
    logic [2:0]  opALU;
    logic        mul_start;
    logic [31:0] memq;
  } ctl_t;

  typedef struct {
    string       name;
    int          dut;
    bit          chk_acc;
    logic [31:0] acc;
    logic        z;
    logic        n;
    bit          chk_c;
    logic        c;
    bit          chk_addr;
    logic [31:0] addr;
    bit          chk_op;
    logic [7:0]  op;
    bit          chk_busy;
    int          exp_cycle;
    int          exp_busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ctl_t ctl [2];

  logic [15:0] memd0;
  logic [23:0] memd1;
  logic [7:0]  maddr0;
  logic [9:0]  maddr1;
  logic [7:0]  opc0;
  logic [7:0]  opc1;
  logic        busy [2];
  logic        done [2];
  logic        zf   [2];
  logic        nf   [2];
  logic        cf   [2];

  int   checks  = 0;
  int   errors  = 0;
  int   cyc_cnt = 0;
  exp_t q_chk  [$];
  exp_t q_done [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  acc_datapath_gen #(.DATA_W(16), .ADDR_W(8), .OP_W(8)) dut0 (
    .clk(clk), .rst(rst),
    .muxPC(ctl[0].muxPC), .muxMAR(ctl[0].muxMAR), .muxACC(ctl[0].muxACC),
    .loadPC(ctl[0].loadPC), .loadMAR(ctl[0].loadMAR), .loadACC(ctl[0].loadACC),
    .loadMDR(ctl[0].loadMDR), .loadIR(ctl[0].loadIR), .opALU(ctl[0].opALU),
    .mul_start(ctl[0].mul_start), .MemQ(ctl[0].memq[15:0]),
    .mul_busy(busy[0]), .mul_done(done[0]), .opcode(opc0), .MemAddr(maddr0),
    .MemD(memd0), .zflag(zf[0]), .nflag(nf[0]), .cflag(cf[0])
  );

  acc_datapath_gen #(.DATA_W(24), .ADDR_W(10), .OP_W(8)) dut1 (
    .clk(clk), .rst(rst),
    .muxPC(ctl[1].muxPC), .muxMAR(ctl[1].muxMAR), .muxACC(ctl[1].muxACC),
    .loadPC(ctl[1].loadPC), .loadMAR(ctl[1].loadMAR), .loadACC(ctl[1].loadACC),
    .loadMDR(ctl[1].loadMDR), .loadIR(ctl[1].loadIR), .opALU(ctl[1].opALU),
    .mul_start(ctl[1].mul_start), .MemQ(ctl[1].memq[23:0]),
    .mul_busy(busy[1]), .mul_done(done[1]), .opcode(opc1), .MemAddr(maddr1),
    .MemD(memd1), .zflag(zf[1]), .nflag(nf[1]), .cflag(cf[1])
  );

  function automatic logic [31:0] acc_of(int d);
    return (d == 0) ? {16'h0, memd0} : {8'h0, memd1};
  endfunction

  function automatic logic [31:0] addr_of(int d);
    return (d == 0) ? {24'h0, maddr0} : {22'h0, maddr1};
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp_v);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  exp_t wb_item  [2];
  bit   wb_pend  [2];
  int   busy_cnt [2];

  always @(negedge clk) begin
    exp_t it;
    for (int d = 0; d < 2; d++) begin
      // Product lands in ACC on the edge that closes the DONE cycle.
      if (wb_pend[d]) begin
        wb_pend[d] = 1'b0;
        cmp({wb_item[d].name, " acc"},   acc_of(d),    wb_item[d].acc);
        cmp({wb_item[d].name, " zflag"}, {31'b0, zf[d]}, {31'b0, wb_item[d].z});
        cmp({wb_item[d].name, " nflag"}, {31'b0, nf[d]}, {31'b0, wb_item[d].n});
        cmp({wb_item[d].name, " cflag"}, {31'b0, cf[d]}, {31'b0, wb_item[d].c});
      end
      if (rst) begin
        busy_cnt[d] = 0;
        wb_pend[d]  = 1'b0;
      end else if (busy[d]) begin
        busy_cnt[d]++;
      end
      if (done[d]) begin
        if (q_done.size() == 0 || q_done[0].dut != d) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: dut%0d pulsed mul_done at cycle %0d, expected none", d, cyc_cnt);
        end else begin
          it = q_done.pop_front();
          cmp({it.name, " done_cycle"},  32'(cyc_cnt),     32'(it.exp_cycle));
          cmp({it.name, " busy_cycles"}, 32'(busy_cnt[d]), 32'(it.exp_busy));
          cmp({it.name, " busy_in_done"}, {31'b0, busy[d]}, 32'd0);
          wb_item[d] = it;
          wb_pend[d] = 1'b1;
        end
        busy_cnt[d] = 0;
      end
    end
    while (q_chk.size() > 0) begin
      it = q_chk.pop_front();
      if (it.chk_acc) begin
        cmp({it.name, " acc"},   acc_of(it.dut), it.acc);
        cmp({it.name, " zflag"}, {31'b0, zf[it.dut]}, {31'b0, it.z});
        cmp({it.name, " nflag"}, {31'b0, nf[it.dut]}, {31'b0, it.n});
      end
      if (it.chk_c)
        cmp({it.name, " cflag"}, {31'b0, cf[it.dut]}, {31'b0, it.c});
      if (it.chk_addr)
        cmp({it.name, " MemAddr"}, addr_of(it.dut), it.addr);
      if (it.chk_op)
        cmp({it.name, " opcode"}, {24'h0, (it.dut == 0) ? opc0 : opc1}, {24'h0, it.op});
      if (it.chk_busy)
        cmp({it.name, " mul_busy"}, {31'b0, busy[it.dut]}, 32'd0);
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard push helpers
  // --------------------------------------------------------------------------
  task automatic push_chk(string nm, int d, bit ca, logic [31:0] a, logic zz,
                          logic nn, bit cc, logic cv, bit cad, logic [31:0] ad,
                          bit cop, logic [7:0] op, bit cb);
    exp_t it;
    it.name = nm;  it.dut = d;
    it.chk_acc = ca;  it.acc = a;  it.z = zz;  it.n = nn;
    it.chk_c = cc;    it.c = cv;
    it.chk_addr = cad; it.addr = ad;
    it.chk_op = cop;  it.op = op;
    it.chk_busy = cb;
    it.exp_cycle = 0; it.exp_busy = 0;
    q_chk.push_back(it);
  endtask

  task automatic exp_acc(string nm, int d, logic [31:0] a, logic zz, logic nn, logic cv);
    push_chk(nm, d, 1'b1, a, zz, nn, 1'b1, cv, 1'b0, 32'h0, 1'b0, 8'h0, 1'b0);
  endtask

  task automatic exp_addr(string nm, int d, logic [31:0] ad);
    push_chk(nm, d, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ad, 1'b0, 8'h0, 1'b0);
  endtask

  task automatic exp_op(string nm, int d, logic [7:0] op);
    push_chk(nm, d, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, op, 1'b0);
  endtask

  task automatic exp_reset(string nm, int d);
    push_chk(nm, d, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 8'h0, 1'b1);
  endtask

  // Latency is counted from the cycle in which mul_start is driven; the
  // start edge follows one cycle later and done shows W cycles after it.
  task automatic push_done(string nm, int d, logic [31:0] a, logic nn, int half_w);
    exp_t it;
    it.name = nm;  it.dut = d;
    it.chk_acc = 1'b1; it.acc = a; it.z = (a == 32'h0); it.n = nn;
    it.chk_c = 1'b1;   it.c = 1'b0;
    it.chk_addr = 1'b0; it.addr = 32'h0;
    it.chk_op = 1'b0;  it.op = 8'h0;
    it.chk_busy = 1'b0;
    it.exp_cycle = cyc_cnt + 1 + half_w;
    it.exp_busy  = half_w;
    q_done.push_back(it);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      ctl[d].loadPC    = 1'b0;
      ctl[d].loadMAR   = 1'b0;
      ctl[d].loadACC   = 1'b0;
      ctl[d].loadMDR   = 1'b0;
      ctl[d].loadIR    = 1'b0;
      ctl[d].mul_start = 1'b0;
    end
  endtask

  task automatic set_mdr(int d, logic [31:0] v);
    ctl[d].memq = v; ctl[d].loadMDR = 1'b1; tick();
  endtask

  task automatic set_acc(int d, logic [31:0] v);
    set_mdr(d, v); ctl[d].muxACC = MUXACC_MDR; ctl[d].loadACC = 1'b1; tick();
  endtask

  task automatic set_ir(int d, logic [31:0] v);
    set_mdr(d, v); ctl[d].loadIR = 1'b1; tick();
  endtask

  task automatic run_alu(int d, logic [2:0] op, logic [31:0] mdr_v);
    set_mdr(d, mdr_v);
    ctl[d].opALU = op; ctl[d].muxACC = MUXACC_ALU; ctl[d].loadACC = 1'b1; tick();
  endtask

  task automatic load_pc(int d, logic sel);
    ctl[d].muxPC = sel; ctl[d].loadPC = 1'b1; tick();
  endtask

  task automatic load_mar(int d, logic sel);
    ctl[d].muxMAR = sel; ctl[d].loadMAR = 1'b1; tick();
  endtask

  task automatic wait_done(int d);
    int k;
    k = 0;
    while (!done[d] && k < 40) begin
      tick();
      k++;
    end
    if (!done[d]) begin
      checks++;
      errors++;
      $display("FAIL mul_done_timeout: dut%0d no mul_done within %0d cycles, expected a pulse", d, k);
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    for (int d = 0; d < 2; d++) ctl[d] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_reset("reset0", 0);
    exp_reset("reset1", 1);
    tick();
    rst = 1'b0;
    tick();

    // PC wrap and IR address / opcode fields
    set_ir(0, 32'hFF00);
    load_pc(0, MUXPC_IR);
    load_mar(0, MUXMAR_PC);   exp_addr("pc_ff", 0, 32'hFF);
    load_pc(0, MUXPC_INC);
    load_mar(0, MUXMAR_PC);   exp_addr("pc_wrap", 0, 32'h00);
    set_ir(0, 32'h4207);      exp_op("opcode_07", 0, 8'h07);
    load_pc(0, MUXPC_IR);
    load_mar(0, MUXMAR_PC);   exp_addr("pc_jump", 0, 32'h42);
    load_pc(0, MUXPC_INC);
    load_mar(0, MUXMAR_PC);   exp_addr("pc_inc", 0, 32'h43);
    load_mar(0, MUXMAR_IR);   exp_addr("mar_irfield", 0, 32'h42);

    // ALU and carry
    set_acc(0, 32'hFFFF);
    run_alu(0, ALU_ADD, 32'h0001);  exp_acc("add_carry", 0, 32'h0000, 1'b1, 1'b0, 1'b1);
    set_acc(0, 32'h0005);           exp_acc("mux_mdr_keeps_c", 0, 32'h0005, 1'b0, 1'b0, 1'b1);
    run_alu(0, ALU_SUB, 32'h0007);  exp_acc("sub_borrow", 0, 32'hFFFE, 1'b0, 1'b1, 1'b0);
    set_acc(0, 32'h0007);
    run_alu(0, ALU_SUB, 32'h0007);  exp_acc("sub_equal", 0, 32'h0000, 1'b1, 1'b0, 1'b1);
    set_acc(0, 32'hF0F0);
    run_alu(0, ALU_AND, 32'h3C3C);  exp_acc("and", 0, 32'h3030, 1'b0, 1'b0, 1'b0);
    run_alu(0, ALU_OR,  32'h0C0F);  exp_acc("or", 0, 32'h3C3F, 1'b0, 1'b0, 1'b0);
    set_acc(0, 32'h8001);
    run_alu(0, ALU_SHL, 32'h0000);  exp_acc("shl", 0, 32'h0002, 1'b0, 1'b0, 1'b1);
    run_alu(0, ALU_NOT, 32'h0000);  exp_acc("not", 0, 32'hFFFD, 1'b0, 1'b1, 1'b0);
    set_acc(0, 32'h0003);
    run_alu(0, ALU_SHR, 32'h0000);  exp_acc("shr", 0, 32'h0001, 1'b0, 1'b0, 1'b1);
    run_alu(0, ALU_PASS, 32'h5A5A); exp_acc("pass", 0, 32'h5A5A, 1'b0, 1'b0, 1'b0);
    set_acc(0, 32'h8000);
    run_alu(0, ALU_SHL, 32'h0000);  exp_acc("shl_out", 0, 32'h0000, 1'b1, 1'b0, 1'b1);

    // Multiply 0xFF x 0x03 with collisions during RUN and DONE
    set_acc(0, 32'h00FF);
    set_mdr(0, 32'h0003);
    ctl[0].mul_start = 1'b1;
    push_done("mul_ff_x_3", 0, 32'h02FD, 1'b0, 8);
    tick();
    tick();
    ctl[0].mul_start = 1'b1;        // ignored while busy
    ctl[0].memq = 32'h1234; ctl[0].loadMDR = 1'b1;
    tick();
    ctl[0].muxACC = MUXACC_MDR; ctl[0].loadACC = 1'b1;
    tick();                          exp_acc("ld_acc_in_run", 0, 32'h1234, 1'b0, 1'b0, 1'b1);
    wait_done(0);
    ctl[0].muxACC = MUXACC_MDR; ctl[0].loadACC = 1'b1; ctl[0].mul_start = 1'b1;
    tick();

    // mul_start together with loadACC: operand is the pre-edge ACC
    set_acc(0, 32'h0012);
    set_mdr(0, 32'h0034);
    ctl[0].mul_start = 1'b1; ctl[0].muxACC = MUXACC_MDR; ctl[0].loadACC = 1'b1;
    push_done("mul_12_x_34", 0, 32'h03A8, 1'b0, 8);
    tick();                          exp_acc("ld_acc_at_start", 0, 32'h0034, 1'b0, 1'b0, 1'b0);
    wait_done(0);
    tick();

    // Reset in the middle of a multiply
    set_acc(0, 32'h00FF);
    set_mdr(0, 32'h0003);
    ctl[0].mul_start = 1'b1;
    tick();
    repeat (3) tick();
    rst = 1'b1;                      exp_reset("rst_mid_mul", 0);
    tick();
    rst = 1'b0;
    tick();                          exp_reset("after_rst_mid_mul", 0);
    repeat (14) tick();

    // Wide configuration: 24/10/8
    set_ir(1, 32'h00A9_4007);
    load_mar(1, MUXMAR_IR);          exp_addr("w24_irfield", 1, 32'h2A5);
                                     exp_op("w24_opcode", 1, 8'h07);
    set_acc(1, 32'h00FF_FFFF);
    run_alu(1, ALU_ADD, 32'h0000_0001); exp_acc("w24_add_carry", 1, 32'h0, 1'b1, 1'b0, 1'b1);
    set_acc(1, 32'h0000_0FFF);
    set_mdr(1, 32'h0000_0FFF);
    ctl[1].mul_start = 1'b1;
    push_done("w24_mul_fff", 1, 32'h00FF_E001, 1'b1, 12);
    tick();
    wait_done(1);
    repeat (14) tick();

    cmp("done_queue_drained", 32'(q_done.size()), 32'd0);
    cmp("chk_queue_drained",  32'(q_chk.size()),  32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_acc_datapath_gen
`default_nettype wire

// File: doc/acc_datapath_gen.md
Name: acc_datapath_gen

Overview:
- Parametrised accumulator datapath for the multi-cycle CPU.
- Holds PC, IR, ACC, MDR, MAR and a carry flag.
- Adds a widened ALU op set and an integrated serial multiplier with a start/busy/done handshake.
- Driven by the control FSM. Its memory port connects to the unified instruction/data RAM.

Parameters:
- DATA_W, 16, width of ACC, MDR, IR, MemD, MemQ. Must be even and >= ADDR_W+OP_W.
- ADDR_W, 8, width of PC, MAR, MemAddr and the IR address field.
- OP_W, 8, width of the opcode field (IR[OP_W-1:0]).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- muxPC  in  1  PC source: 0 = PC+1, 1 = IR address field.
- muxMAR  in  1  MAR source: 0 = PC, 1 = IR address field.
- muxACC  in  1  ACC source: 0 = ALU_out, 1 = MDR.
- loadPC, loadMAR, loadACC, loadMDR, loadIR  in  1 each  register load enables.
- opALU  in  3  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT ACC, 5 PASS MDR, 6 SHL ACC, 7 SHR ACC (logical).
- mul_start  in  1  start ACC[DATA_W/2-1:0] x MDR[DATA_W/2-1:0].
- MemQ  in  DATA_W  memory read data.
- mul_busy  out  1  multiplier running.
- mul_done  out  1  one-cycle pulse; product written to ACC this edge.
- opcode  out  OP_W  IR_reg[OP_W-1:0].
- MemAddr  out  ADDR_W  MAR_reg.
- MemD  out  DATA_W  ACC_reg.
- zflag  out  1  ACC_reg == 0.
- nflag  out  1  ACC_reg[DATA_W-1].
- cflag  out  1  registered carry/borrow/shift-out.

Behaviour:
- Reset (async, rst=1): PC, IR, ACC, MDR, MAR = 0. cflag = 0. Multiplier goes to IDLE, mul_busy = 0, mul_done = 0.
- After reset: opcode = 0, MemAddr = 0, MemD = 0, zflag = 1, nflag = 0.
- All outputs derive from registered state only; no next-state values appear on outputs.
- Address field: IR[DATA_W-1:DATA_W-ADDR_W].
- PC: updates only when loadPC is high. PC+1 wraps 2^ADDR_W-1 -> 0.
- MAR: updates only when loadMAR is high. IR: loads MDR when loadIR is high. MDR: loads MemQ when loadMDR is high.
- Hold is the default for every register.
- ALU is combinational. Result is truncated to DATA_W.
- Carry (internal, captured into cflag only on loadACC with muxACC=0):
  - ADD: carry out of bit DATA_W-1.
  - SUB: ACC-MDR, carry = 1 when no borrow (ACC >= MDR unsigned).
  - SHL: old ACC msb. SHR: old ACC lsb.
  - AND/OR/NOT/PASS: cflag cleared.
- loadACC with muxACC=1 leaves cflag unchanged.
- Multiplier FSM states:
  - IDLE: on mul_start, latch both DATA_W/2-bit operands, clear the product, count = 0, go to RUN. mul_busy = 1 from the next cycle.
  - RUN: one shift-add step per cycle. After DATA_W/2 steps go to DONE.
  - DONE: one cycle. mul_done = 1, ACC <= product, mul_busy = 0, cflag = 0. Next state is IDLE.
- Latency: mul_done asserts exactly DATA_W/2+1 cycles after the mul_start edge (9 at default).
- mul_start while busy or in DONE is ignored; there is no restart.
- mul_start in the same cycle as loadACC: operands are taken from the pre-edge ACC, and the loadACC still occurs.
- During RUN, loadACC/loadMDR are legal. Operands are already latched, so the result is unaffected.
- In DONE, the multiplier writeback has priority over loadACC; the simultaneous loadACC is dropped.
- rst during RUN aborts: IDLE, no mul_done, ACC = 0.

Decomposition:
- Shared package acc_dp_pkg: opALU encodings as localparams (ALU_ADD .. ALU_SHR), multiplier state encoding (MS_IDLE, MS_RUN, MS_DONE), mux select constants.
- Sub-module mul_serial (params W = DATA_W/2):
  - Inputs: clk, rst, start, a, b.
  - Outputs: busy, done, prod[2W-1:0].
- Registers and ALU live in the top module.

Test Plan:
- Reset mid-run: assert rst at any point, including mid-multiply (e.g. 3 cycles after mul_start) -> all registers 0, zflag = 1, MemAddr = 0, mul_busy = 0, no mul_done pulse.
- PC wrap: PC = 0xFF, loadPC, muxPC = 0 -> PC = 0x00. IR = 0x4207, loadPC, muxPC = 1 -> PC = 0x42, opcode = 0x07.
- ADD carry: ACC = 0xFFFF, MDR = 0x0001, ADD -> ACC = 0, zflag = 1, cflag = 1. SUB with ACC = 5, MDR = 7 -> ACC = 0xFFFE, nflag = 1, cflag = 0.
- Multiply: ACC = 0x00FF, MDR = 0x0003, pulse mul_start -> mul_busy for 8 cycles, mul_done at cycle 9, ACC = 0x02FD, cflag = 0.
- Collisions: mul_start while busy -> ignored, single mul_done. loadACC with muxACC=1 (MDR = 0x1234) in the DONE cycle -> ACC = product, not 0x1234.
- Parameter sweep: DATA_W = 24, ADDR_W = 10, OP_W = 8 -> IR address field IR[23:14], 12 x 12 multiply 0xFFF x 0xFFF = 0xFFE001 after 13 cycles.
